// File: rtl/data_path.sv
// data_path: single-cycle RV32I-style datapath (PC, 32x32 register file,
// immediate generator, ALU, branch comparator, writeback mux).
//
// Ports
//   clk            sole clock, rising-edge
//   reset          async active-low; 0 clears PC and every register
//   write_ctrl     register-file write enable (ignored for rd = x0)
//   operand_ctrl   ALU B select: 0 = rs2 value, 1 = immediate
//   load_ctrl      writeback select: 0 = alu_out, 1 = mem_read_data
//   branch_flag    current instruction is a conditional branch
//   instr_op       current instruction word
//   ctrl_op        ALU operation code
//   mem_read_data  data-memory read data
//   instr_addr     PC (instruction-memory address)
//   alu_out        ALU result / data-memory address
//   data_read_2    rs2 value / store data

// Sign-extended immediate, format chosen by opcode.
module dp_imm_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  always_comb begin
    imm = '0;
    unique case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm = {{20{instr[31]}}, instr[31:20]};
      7'b0100011:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {instr[31:12], 12'b0};
      7'b1101111:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end
endmodule

// Combinational ALU; undefined codes produce 0.
module dp_alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    unique case (op)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: y = a + b;
      4'b0011: y = a ^ b;
      4'b0100: y = a << shamt;
      4'b0101: y = a >> shamt;
      4'b1001: y = $unsigned($signed(a) >>> shamt);
      4'b0110: y = a - b;
      4'b0111: y = {31'b0, $signed(a) < $signed(b)};
      4'b1000: y = {31'b0, a < b};
      default: y = '0;
    endcase
  end
endmodule

// Branch condition from funct3; 010/011 are never taken.
module dp_br_cmp (
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        take
);
  always_comb begin
    take = 1'b0;
    unique case (funct3)
      3'b000:  take = (a == b);
      3'b001:  take = (a != b);
      3'b100:  take = ($signed(a) <  $signed(b));
      3'b101:  take = ($signed(a) >= $signed(b));
      3'b110:  take = (a <  b);
      3'b111:  take = (a >= b);
      default: take = 1'b0;
    endcase
  end
endmodule

module data_path (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_ctrl,
  input  logic        operand_ctrl,
  input  logic        load_ctrl,
  input  logic        branch_flag,
  input  logic [31:0] instr_op,
  input  logic [3:0]  ctrl_op,
  input  logic [31:0] mem_read_data,
  output logic [31:0] instr_addr,
  output logic [31:0] alu_out,
  output logic [31:0] data_read_2
);
  localparam int NREG = 32;

  logic [31:0] pc;
  logic [31:0] rf [NREG];
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val, imm, alu_b, wb_data, pc_next;
  logic        br_take;

  assign rs1 = instr_op[19:15];
  assign rs2 = instr_op[24:20];
  assign rd  = instr_op[11:7];

  // x0 is held at zero in storage, so reads need no special case.
  // Reads see pre-edge contents: no write-to-read bypass.
  assign rs1_val = rf[rs1];
  assign rs2_val = rf[rs2];

  dp_imm_gen u_imm (
    .instr (instr_op),
    .imm   (imm)
  );

  assign alu_b = operand_ctrl ? imm : rs2_val;

  dp_alu u_alu (
    .op (ctrl_op),
    .a  (rs1_val),
    .b  (alu_b),
    .y  (alu_out)
  );

  dp_br_cmp u_br (
    .funct3 (instr_op[14:12]),
    .a      (rs1_val),
    .b      (rs2_val),
    .take   (br_take)
  );

  assign wb_data     = load_ctrl ? mem_read_data : alu_out;
  assign pc_next     = (branch_flag && br_take) ? (pc + imm) : (pc + 32'd4);
  assign instr_addr  = pc;
  assign data_read_2 = rs2_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      rf[0] <= '0;
      for (int i = 1; i < NREG; i++)
        if (write_ctrl && rd == 5'(i)) rf[i] <= wb_data;
    end
  end
endmodule

// File: tb/tb_data_path.sv
// Randomized self-checking bench for data_path with a behavioural reference
// model (register array + PC) plus a directed RV32I sequence.
module tb_data_path;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_ctrl = 1'b0, operand_ctrl = 1'b0, load_ctrl = 1'b0, branch_flag = 1'b0;
  logic [31:0] instr_op = '0;
  logic [3:0]  ctrl_op = '0;
  logic [31:0] mem_read_data = '0;
  logic [31:0] instr_addr, alu_out, data_read_2;

  int errors = 0;
  int checks = 0;

  logic [31:0] mreg [32];
  logic [31:0] mpc;

  data_path dut (
    .clk(clk), .reset(reset), .write_ctrl(write_ctrl), .operand_ctrl(operand_ctrl),
    .load_ctrl(load_ctrl), .branch_flag(branch_flag), .instr_op(instr_op),
    .ctrl_op(ctrl_op), .mem_read_data(mem_read_data), .instr_addr(instr_addr),
    .alu_out(alu_out), .data_read_2(data_read_2)
  );

  always #50 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return sx(ins >> 20, 12);
      7'h23: return sx(((ins >> 25) << 5) | ((ins >> 7) & 32'h1F), 12);
      7'h63: return sx((ins[31] << 12) | (ins[7] << 11) | (((ins >> 25) & 32'h3F) << 5)
                       | (((ins >> 8) & 32'hF) << 1), 13);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return sx((ins[31] << 20) | (((ins >> 12) & 32'hFF) << 12)
                       | (ins[20] << 11) | (((ins >> 21) & 32'h3FF) << 1), 21);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b % 32);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return a << s;
      4'd5: return a >> s;
      4'd9: return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd6: return a + ~b + 32'd1;
      4'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_take(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) <  int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) mreg[r] = '0;
    mpc = '0;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic [31:0] ins, input logic [3:0] op, input logic opnd,
                       input logic ld, input logic wr, input logic br, input logic [31:0] mrd);
    instr_op = ins; ctrl_op = op; operand_ctrl = opnd; load_ctrl = ld;
    write_ctrl = wr; branch_flag = br; mem_read_data = mrd;
  endtask

  // One instruction: starts just after a falling edge, checks combinational
  // outputs against the model, clocks, then advances the model.
  task automatic step(input logic [31:0] ins, input logic [3:0] op, input logic opnd,
                      input logic ld, input logic wr, input logic br, input logic [31:0] mrd);
    logic [31:0] a, b2, imm, y, wb;
    logic [4:0]  rd;
    drive(ins, op, opnd, ld, wr, br, mrd);
    #1;
    a   = mreg[ins[19:15]];
    b2  = mreg[ins[24:20]];
    rd  = ins[11:7];
    imm = m_imm(ins);
    y   = m_alu(op, a, opnd ? imm : b2);
    wb  = ld ? mrd : y;
    chk("alu_out", alu_out, y);
    chk("data_read_2", data_read_2, b2);
    chk("instr_addr", instr_addr, mpc);
    @(posedge clk);
    if (wr && rd != 0) mreg[rd] = wb;
    mpc = (br && m_take(ins[14:12], a, b2)) ? mpc + imm : mpc + 32'd4;
    @(negedge clk);
  endtask

  // Reads a register through the ALU (rs1 | x0) without clocking.
  task automatic rd_reg(input int r, output logic [31:0] v);
    drive(enc_r(7'h0, 5'd0, 5'(r), 3'd0, 5'd0), 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    v = alu_out;
  endtask

  task automatic readout_all(input string tag);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      rd_reg(r, v);
      chk($sformatf("%s_x%0d", tag, r), v, mreg[r]);
    end
  endtask

  logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h33};

  initial begin
    logic [31:0] v, ins;
    logic [6:0]  opc;
    logic        br;

    // Async reset with no clock edge yet.
    #1 reset = 1'b0;
    m_reset();
    #2;
    chk("rst_pc", instr_addr, 32'h0);
    readout_all("rst");
    // Edge while held in reset must not write or advance.
    drive(enc_i(12'd9, 5'd0, 3'd0, 5'd3, 7'h13), 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold_pc", instr_addr, 32'h0);
    @(negedge clk);
    rd_reg(3, v); chk("rst_hold_x3", v, 32'h0);
    reset = 1'b1;

    // Directed program.
    step(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("addi_pc", instr_addr, 32'h4);
    rd_reg(1, v); chk("addi_x1", v, 32'h5);
    step(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13), 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    rd_reg(2, v); chk("addi_x2", v, 32'hFFFF_FFFD);
    step(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    rd_reg(8, v); chk("add_x8", v, 32'h2);
    step(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd8), 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    rd_reg(8, v); chk("sub_x8", v, 32'h8);
    chk("pre_beq_pc", instr_addr, 32'h10);
    step(enc_b(13'd8, 5'd1, 5'd1, 3'd0), 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("beq_pc", instr_addr, 32'h18);
    step(enc_b(13'd8, 5'd1, 5'd1, 3'd1), 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("bne_pc", instr_addr, 32'h1C);
    step(enc_b(13'd8, 5'd1, 5'd2, 3'd4), 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("blt_pc", instr_addr, 32'h24);
    step(enc_b(13'd8, 5'd1, 5'd2, 3'd6), 4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("bltu_pc", instr_addr, 32'h28);
    ins = enc_s(12'd12, 5'd1, 5'd0, 3'd2);
    drive(ins, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("sw_addr", alu_out, 32'hC);
    chk("sw_data", data_read_2, 32'h5);
    step(ins, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(enc_i(12'd12, 5'd0, 3'd2, 5'd9, 7'h03), 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 32'h5);
    rd_reg(9, v); chk("lw_x9", v, 32'h5);
    step(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'h13), 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    rd_reg(0, v); chk("x0_zero", v, 32'h0);
    readout_all("dir");

    // Randomized instructions against the model.
    for (int i = 0; i < 400; i++) begin
      opc = ops[$urandom_range(0, 9)];
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[6:0] = opc;
      br = (ins[6:0] == 7'h63) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      step(ins, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), br, $urandom);
      if (i % 50 == 49) readout_all("rnd");
      if (i == 200) begin
        // Reset pulse between edges must clear state before the next edge.
        #2 reset = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_pc", instr_addr, 32'h0);
        readout_all("mid_rst");
        @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
